// File: rtl/parq_pkg.sv
// Shared types and defaults for the parking-lot occupancy path.
package parq_pkg;

    // Sequence FSM states: entry side (EN*) and exit side (EX*) mirror each other.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EN1  = 3'd1,
        S_EN2  = 3'd2,
        S_EN3  = 3'd3,
        S_EX1  = 3'd4,
        S_EX2  = 3'd5,
        S_EX3  = 3'd6
    } state_t;

    // One BCD digit of the occupancy display.
    typedef logic [3:0] bcd_t;

    // Default lot capacity and debounce settings.
    localparam int unsigned CAP_DEFAULT       = 50;
    localparam int unsigned DB_CYCLES_DEFAULT = 50000;
    localparam int unsigned DBW_DEFAULT       = 16;

    // Debounced beam pair {a,b}: 1 = blocked.
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one beam sensor.
module sensor_debounce
    import parq_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned DBW       = DBW_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    // Counter value on the last differing cycle before the new level is accepted.
    localparam logic [DBW-1:0] CNT_LAST = DBW'(DB_CYCLES - 1);

    logic           sync1;
    logic           sync2;
    logic [DBW-1:0] cnt;

    // Synchronise the raw input, then accept a new level once it has differed for DB_CYCLES cycles.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dout  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + DBW'(1);
            end
        end
    end

endmodule

// File: rtl/lot_occupancy_ctrl.sv
// Beam-sequence decoder and saturating BCD occupancy counter for the lot display.
module lot_occupancy_ctrl
    import parq_pkg::*;
#(
    parameter int unsigned CAP       = CAP_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned DBW       = DBW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic [9:0] occ,
    output bcd_t       dig2,
    output bcd_t       dig1,
    output bcd_t       dig0,
    output logic       full,
    output logic       empty,
    output logic       enter_p,
    output logic       exit_p,
    output logic       err_p
);

    localparam logic [9:0] CAP_V = 10'(CAP);

    logic       ad;
    logic       bd;
    logic [1:0] pair;

    state_t     state_q;
    state_t     state_d;
    logic       ev_entry;
    logic       ev_exit;

    logic [9:0] occ_d;
    bcd_t       dig2_d;
    bcd_t       dig1_d;
    bcd_t       dig0_d;
    logic       enter_d;
    logic       exit_d;
    logic       err_d;

    sensor_debounce #(.DB_CYCLES(DB_CYCLES), .DBW(DBW)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .din   (a),
        .dout  (ad)
    );

    sensor_debounce #(.DB_CYCLES(DB_CYCLES), .DBW(DBW)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .din   (b),
        .dout  (bd)
    );

    assign pair = {ad, bd};

    // Sequence state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode of the ordered blocking sequence; events fire on the final release.
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        ev_entry = 1'b0;
        ev_exit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pair == AB_A)      state_d = S_EN1;
                else if (pair == AB_B) state_d = S_EX1;
            end
            S_EN1: begin
                if (pair == AB_BOTH)   state_d = S_EN2;
                else if (pair != AB_A) state_d = S_IDLE;
            end
            S_EN2: begin
                case (pair)
                    AB_B:    state_d = S_EN3;
                    AB_A:    state_d = S_EN1;
                    AB_NONE: state_d = S_IDLE;
                    default: state_d = S_EN2;
                endcase
            end
            S_EN3: begin
                case (pair)
                    AB_NONE: begin
                        state_d  = S_IDLE;
                        ev_entry = 1'b1;
                    end
                    AB_BOTH: state_d = S_EN2;
                    AB_A:    state_d = S_IDLE;
                    default: state_d = S_EN3;
                endcase
            end
            S_EX1: begin
                if (pair == AB_BOTH)   state_d = S_EX2;
                else if (pair != AB_B) state_d = S_IDLE;
            end
            S_EX2: begin
                case (pair)
                    AB_A:    state_d = S_EX3;
                    AB_B:    state_d = S_EX1;
                    AB_NONE: state_d = S_IDLE;
                    default: state_d = S_EX2;
                endcase
            end
            S_EX3: begin
                case (pair)
                    AB_NONE: begin
                        state_d = S_IDLE;
                        ev_exit = 1'b1;
                    end
                    AB_BOTH: state_d = S_EX2;
                    AB_B:    state_d = S_IDLE;
                    default: state_d = S_EX3;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating up/down count, binary and BCD in lockstep with carry/borrow rippling across digits.
    always_comb begin
        occ_d   = occ;
        dig2_d  = dig2;
        dig1_d  = dig1;
        dig0_d  = dig0;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        if (ev_entry) begin
            if (occ < CAP_V) begin
                occ_d   = occ + 10'd1;
                enter_d = 1'b1;
                if (dig0 == 4'd9) begin
                    dig0_d = 4'd0;
                    if (dig1 == 4'd9) begin
                        dig1_d = 4'd0;
                        dig2_d = dig2 + 4'd1;
                    end else begin
                        dig1_d = dig1 + 4'd1;
                    end
                end else begin
                    dig0_d = dig0 + 4'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (ev_exit) begin
            if (occ != 10'd0) begin
                occ_d  = occ - 10'd1;
                exit_d = 1'b1;
                if (dig0 == 4'd0) begin
                    dig0_d = 4'd9;
                    if (dig1 == 4'd0) begin
                        dig1_d = 4'd9;
                        dig2_d = dig2 - 4'd1;
                    end else begin
                        dig1_d = dig1 - 4'd1;
                    end
                end else begin
                    dig0_d = dig0 - 4'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Register the count, status flags and one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ     <= 10'd0;
            dig2    <= 4'd0;
            dig1    <= 4'd0;
            dig0    <= 4'd0;
            full    <= (CAP_V == 10'd0);
            empty   <= 1'b1;
            enter_p <= 1'b0;
            exit_p  <= 1'b0;
            err_p   <= 1'b0;
        end else begin
            occ     <= occ_d;
            dig2    <= dig2_d;
            dig1    <= dig1_d;
            dig0    <= dig0_d;
            full    <= (occ_d == CAP_V);
            empty   <= (occ_d == 10'd0);
            enter_p <= enter_d;
            exit_p  <= exit_d;
            err_p   <= err_d;
        end
    end

endmodule

// File: tb/tb_lot_occupancy_ctrl.sv
// Directed bench: small-capacity instance for sequencing, CAP=150 instance for BCD ripple.
module tb_lot_occupancy_ctrl;
    import parq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;

    logic [9:0] occ, occ2;
    bcd_t       dig2, dig1, dig0, d2b, d1b, d0b;
    logic       full, empty, enter_p, exit_p, err_p;
    logic       full2, empty2, enter2, exit2, err2;

    int compared = 0;
    int mismatched = 0;
    int enter_cnt = 0;
    int exit_cnt = 0;
    int err_cnt = 0;

    lot_occupancy_ctrl #(.CAP(3), .DB_CYCLES(4), .DBW(16)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .occ(occ), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .full(full), .empty(empty),
        .enter_p(enter_p), .exit_p(exit_p), .err_p(err_p)
    );

    lot_occupancy_ctrl #(.CAP(150), .DB_CYCLES(4), .DBW(16)) dut_bcd (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .occ(occ2), .dig2(d2b), .dig1(d1b), .dig0(d0b),
        .full(full2), .empty(empty2),
        .enter_p(enter2), .exit_p(exit2), .err_p(err2)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse of the small instance is high.
    always @(negedge clk) begin
        if (enter_p === 1'b1) enter_cnt <= enter_cnt + 1;
        if (exit_p === 1'b1)  exit_cnt  <= exit_cnt + 1;
        if (err_p === 1'b1)   err_cnt   <= err_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [1:0] ab, input int n);
        a = ab[1];
        b = ab[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic entry_seq(input int n);
        step(2'b10, n); step(2'b11, n); step(2'b01, n); step(2'b00, n);
    endtask

    task automatic exit_seq(input int n);
        step(2'b01, n); step(2'b11, n); step(2'b10, n); step(2'b00, n);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (occ !== 10'd0) begin mismatched++; $display("FAIL reset_occ: got %0d want 0", occ); end
        compared++; if ({dig2, dig1, dig0} !== 12'h000) begin mismatched++; $display("FAIL reset_digits: got %h want 000", {dig2, dig1, dig0}); end
        compared++; if (empty !== 1'b1 || full !== 1'b0) begin mismatched++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
        compared++; if ({enter_p, exit_p, err_p} !== 3'b000) begin mismatched++; $display("FAIL reset_pulses: got %b want 000", {enter_p, exit_p, err_p}); end
        reset = 1'b0;
        step(2'b00, 4);
    endtask

    task automatic test_entry;
        int e0;
        e0 = enter_cnt;
        entry_seq(10);
        compared++; if (enter_cnt - e0 !== 1) begin mismatched++; $display("FAIL entry_pulse: got %0d cycles want 1", enter_cnt - e0); end
        compared++; if (occ !== 10'd1 || dig0 !== 4'd1) begin mismatched++; $display("FAIL entry_occ: got occ=%0d dig0=%0d want 1/1", occ, dig0); end
        compared++; if (empty !== 1'b0 || full !== 1'b0) begin mismatched++; $display("FAIL entry_flags: got empty=%b full=%b want 0/0", empty, full); end
        entry_seq(10);
        entry_seq(10);
        compared++; if (occ !== 10'd3 || dig0 !== 4'd3) begin mismatched++; $display("FAIL entry3_occ: got occ=%0d dig0=%0d want 3/3", occ, dig0); end
        compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL entry3_full: got %b want 1", full); end
        compared++; if (enter_cnt - e0 !== 3 || err_cnt !== 0) begin mismatched++; $display("FAIL entry3_count: got enter=%0d err=%0d want 3/0", enter_cnt - e0, err_cnt); end
    endtask

    task automatic test_refused_entry;
        int e0, r0, x0;
        e0 = enter_cnt; r0 = err_cnt; x0 = exit_cnt;
        entry_seq(10);
        compared++; if (err_cnt - r0 !== 1 || enter_cnt - e0 !== 0) begin mismatched++; $display("FAIL refused_pulse: got err=%0d enter=%0d want 1/0", err_cnt - r0, enter_cnt - e0); end
        compared++; if (occ !== 10'd3 || full !== 1'b1) begin mismatched++; $display("FAIL refused_occ: got occ=%0d full=%b want 3/1", occ, full); end
        exit_seq(10);
        compared++; if (exit_cnt - x0 !== 1) begin mismatched++; $display("FAIL exit_pulse: got %0d cycles want 1", exit_cnt - x0); end
        compared++; if (occ !== 10'd2 || dig0 !== 4'd2 || full !== 1'b0) begin mismatched++; $display("FAIL exit_occ: got occ=%0d dig0=%0d full=%b want 2/2/0", occ, dig0, full); end
    endtask

    task automatic test_bounce;
        int e0, x0, r0;
        bit ad_moved;
        e0 = enter_cnt; x0 = exit_cnt; r0 = err_cnt;
        ad_moved = 1'b0;
        b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = ~a;
            repeat (2) begin
                @(negedge clk);
                if (dut.u_deb_a.dout !== 1'b0) ad_moved = 1'b1;
            end
        end
        step(2'b00, 10);
        compared++; if (ad_moved !== 1'b0) begin mismatched++; $display("FAIL bounce_ad: got debounced a moved=%b want 0", ad_moved); end
        compared++; if (dut.state_q !== S_IDLE) begin mismatched++; $display("FAIL bounce_state: got %0d want %0d", dut.state_q, S_IDLE); end
        step(2'b10, 10); step(2'b11, 10); step(2'b10, 10); step(2'b00, 10);
        compared++; if (enter_cnt - e0 !== 0 || exit_cnt - x0 !== 0 || err_cnt - r0 !== 0) begin mismatched++; $display("FAIL backout_events: got enter=%0d exit=%0d err=%0d want 0/0/0", enter_cnt - e0, exit_cnt - x0, err_cnt - r0); end
        compared++; if (dut.state_q !== S_IDLE || occ !== 10'd2) begin mismatched++; $display("FAIL backout_state: got state=%0d occ=%0d want %0d/2", dut.state_q, occ, S_IDLE); end
    endtask

    task automatic test_exit_empty;
        int x0, r0;
        exit_seq(10);
        exit_seq(10);
        compared++; if (occ !== 10'd0 || empty !== 1'b1 || dig0 !== 4'd0) begin mismatched++; $display("FAIL drain_occ: got occ=%0d empty=%b dig0=%0d want 0/1/0", occ, empty, dig0); end
        x0 = exit_cnt; r0 = err_cnt;
        exit_seq(10);
        compared++; if (err_cnt - r0 !== 1 || exit_cnt - x0 !== 0) begin mismatched++; $display("FAIL empty_exit_pulse: got err=%0d exit=%0d want 1/0", err_cnt - r0, exit_cnt - x0); end
        compared++; if (occ !== 10'd0 || empty !== 1'b1) begin mismatched++; $display("FAIL empty_exit_occ: got occ=%0d empty=%b want 0/1", occ, empty); end
    endtask

    task automatic test_reset_mid_sequence;
        int e0, x0, r0;
        entry_seq(10);
        compared++; if (occ !== 10'd1) begin mismatched++; $display("FAIL mid_pre_occ: got %0d want 1", occ); end
        step(2'b10, 10); step(2'b11, 10);
        compared++; if (dut.state_q !== S_EN2) begin mismatched++; $display("FAIL mid_en2: got %0d want %0d", dut.state_q, S_EN2); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compared++; if (dut.state_q !== S_IDLE || occ !== 10'd0 || empty !== 1'b1) begin mismatched++; $display("FAIL mid_reset: got state=%0d occ=%0d empty=%b want %0d/0/1", dut.state_q, occ, empty, S_IDLE); end
        step(2'b11, 10);
        e0 = enter_cnt; x0 = exit_cnt; r0 = err_cnt;
        step(2'b01, 10); step(2'b00, 10);
        compared++; if (enter_cnt - e0 !== 0 || exit_cnt - x0 !== 0 || err_cnt - r0 !== 0) begin mismatched++; $display("FAIL mid_no_event: got enter=%0d exit=%0d err=%0d want 0/0/0", enter_cnt - e0, exit_cnt - x0, err_cnt - r0); end
        compared++; if (dut.state_q !== S_IDLE || occ !== 10'd0) begin mismatched++; $display("FAIL mid_final: got state=%0d occ=%0d want %0d/0", dut.state_q, occ, S_IDLE); end
    endtask

    task automatic test_bcd_carry;
        reset = 1'b1;
        step(2'b00, 2);
        reset = 1'b0;
        step(2'b00, 4);
        for (int i = 0; i < 9; i++) entry_seq(8);
        compared++; if ({d2b, d1b, d0b} !== 12'h009 || occ2 !== 10'd9) begin mismatched++; $display("FAIL bcd_9: got %h occ=%0d want 009/9", {d2b, d1b, d0b}, occ2); end
        for (int i = 0; i < 10; i++) entry_seq(8);
        compared++; if ({d2b, d1b, d0b} !== 12'h019 || occ2 !== 10'd19) begin mismatched++; $display("FAIL bcd_19: got %h occ=%0d want 019/19", {d2b, d1b, d0b}, occ2); end
        for (int i = 0; i < 80; i++) entry_seq(8);
        compared++; if ({d2b, d1b, d0b} !== 12'h099 || occ2 !== 10'd99) begin mismatched++; $display("FAIL bcd_99: got %h occ=%0d want 099/99", {d2b, d1b, d0b}, occ2); end
        entry_seq(8);
        compared++; if ({d2b, d1b, d0b} !== 12'h100 || occ2 !== 10'd100) begin mismatched++; $display("FAIL bcd_100: got %h occ=%0d want 100/100", {d2b, d1b, d0b}, occ2); end
        exit_seq(8);
        compared++; if ({d2b, d1b, d0b} !== 12'h099 || occ2 !== 10'd99 || full2 !== 1'b0) begin mismatched++; $display("FAIL bcd_borrow: got %h occ=%0d full=%b want 099/99/0", {d2b, d1b, d0b}, occ2, full2); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_refused_entry();
        test_bounce();
        test_exit_empty();
        test_reset_mid_sequence();
        test_bcd_carry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
